paint_arbiter: RTL

PAINT_ARBITER -- requirements
Module: paint_arbiter

---
 rtl/paint_arbiter_pkg.sv | 15 +
 rtl/paint_arbiter_scanner.sv | 71 +++++++
 rtl/paint_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/paint_arbiter_pkg.sv
// Shared definitions for the paint arbiter: FSM encoding, screen defaults and coordinate width.
package paint_arbiter_pkg;

  localparam int COORD_W   = 11;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STAMP = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/paint_arbiter_scanner.sv
// Row-major rectangle scanner shared by stamp and clear. Coordinates are held at
// 12 bits so that a stamp running past the right/bottom edge never wraps back
// into the visible area; such pixels are reported invalid and skipped at once.
module rect_scanner
  import paint_arbiter_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_run,
  input  logic               i_ready,
  input  logic [COORD_W-1:0] i_x0,
  input  logic [COORD_W-1:0] i_y0,
  input  logic [COORD_W:0]   i_x_end,
  input  logic [COORD_W:0]   i_y_end,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_valid,
  output logic               o_advance,
  output logic               o_last
);

  localparam logic [COORD_W:0] X_LIM = (COORD_W+1)'(H_RES);
  localparam logic [COORD_W:0] Y_LIM = (COORD_W+1)'(V_RES);

  logic [COORD_W:0] r_x;
  logic [COORD_W:0] r_y;
  logic [COORD_W:0] r_x0;
  logic [COORD_W:0] r_x_end;
  logic [COORD_W:0] r_y_end;
  logic             w_in_bounds;

  assign w_in_bounds = (r_x < X_LIM) && (r_y < Y_LIM);
  assign o_valid     = i_run && w_in_bounds;
  // Off-screen pixels never wait for the framebuffer.
  assign o_advance   = i_run && (!w_in_bounds || i_ready);
  assign o_last      = (r_x == r_x_end) && (r_y == r_y_end);
  assign o_x         = r_x[COORD_W-1:0];
  assign o_y         = r_y[COORD_W-1:0];

  // Scan position: load origin on start, then step row-major on each advance.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_load) begin
      r_x <= {1'b0, i_x0};
      r_y <= {1'b0, i_y0};
    end else if (o_advance) begin
      if (r_x == r_x_end) begin
        r_x <= r_x0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // Rectangle bounds captured once per operation.
  always_ff @(posedge clock) begin
    if (i_load) begin
      r_x0    <= {1'b0, i_x0};
      r_x_end <= i_x_end;
      r_y_end <= i_y_end;
    end
  end

endmodule

// File: rtl/paint_arbiter.sv
// Paint arbiter: arbitrates brush stamps and full-screen clears onto a single
// framebuffer write port. A clear requested mid-stamp is remembered and run
// straight after the stamp completes.
module paint_arbiter
  import paint_arbiter_pkg::*;
#(
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int COLOR_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_stamp_req,
  input  logic [COORD_W-1:0] i_x_cursor,
  input  logic [COORD_W-1:0] i_y_cursor,
  input  logic [6:0]         i_size,
  input  logic [COLOR_W-1:0] i_brush_color,
  input  logic               i_clear_req,
  input  logic [COLOR_W-1:0] i_clear_color,
  output logic               o_wr_en,
  output logic [COORD_W-1:0] o_wr_x,
  output logic [COORD_W-1:0] o_wr_y,
  output logic [COLOR_W-1:0] o_wr_color,
  input  logic               i_wr_ready,
  output logic               o_busy,
  output logic               o_stamp_done,
  output logic               o_clear_done
);

  localparam logic [COORD_W:0] X_LAST = (COORD_W+1)'(H_RES - 1);
  localparam logic [COORD_W:0] Y_LAST = (COORD_W+1)'(V_RES - 1);

  state_t             r_state;
  state_t             w_next;
  logic               r_pending;
  logic               r_is_clear;
  logic [COLOR_W-1:0] r_color;
  logic               w_load;
  logic               w_load_clear;
  logic               w_run;
  logic               w_advance;
  logic               w_last;
  logic [COORD_W-1:0] w_x0;
  logic [COORD_W-1:0] w_y0;
  logic [COORD_W:0]   w_x_end;
  logic [COORD_W:0]   w_y_end;

  assign w_run = (r_state == ST_STAMP) || (r_state == ST_CLEAR);

  rect_scanner #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_scanner (
    .clock     (clock),
    .reset     (reset),
    .i_load    (w_load),
    .i_run     (w_run),
    .i_ready   (i_wr_ready),
    .i_x0      (w_x0),
    .i_y0      (w_y0),
    .i_x_end   (w_x_end),
    .i_y_end   (w_y_end),
    .o_x       (o_wr_x),
    .o_y       (o_wr_y),
    .o_valid   (o_wr_en),
    .o_advance (w_advance),
    .o_last    (w_last)
  );

  // Next-state selection plus the operation bounds loaded on each start.
  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_load_clear = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_clear_req) begin
          w_next       = ST_CLEAR;
          w_load       = 1'b1;
          w_load_clear = 1'b1;
        end else if (i_stamp_req) begin
          w_next = ST_STAMP;
          w_load = 1'b1;
        end
      end
      ST_STAMP, ST_CLEAR: begin
        if (w_advance && w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        if (r_pending) begin
          w_next       = ST_CLEAR;
          w_load       = 1'b1;
          w_load_clear = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    w_x0    = w_load_clear ? '0 : i_x_cursor;
    w_y0    = w_load_clear ? '0 : i_y_cursor;
    w_x_end = w_load_clear ? X_LAST : ({1'b0, i_x_cursor} + {5'b0, i_size});
    w_y_end = w_load_clear ? Y_LAST : ({1'b0, i_y_cursor} + {5'b0, i_size});
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Pending clear, operation kind and latched colour.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pending  <= 1'b0;
      r_is_clear <= 1'b0;
      r_color    <= '0;
    end else begin
      if (r_state == ST_DONE && r_pending) r_pending <= 1'b0;
      else if (r_state == ST_STAMP && i_clear_req) r_pending <= 1'b1;
      if (w_load) begin
        r_is_clear <= w_load_clear;
        r_color    <= w_load_clear ? i_clear_color : i_brush_color;
      end
    end
  end

  assign o_wr_color   = r_color;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_stamp_done = (r_state == ST_DONE) && !r_is_clear;
  assign o_clear_done = (r_state == ST_DONE) && r_is_clear;

endmodule
